branch_predictor: RTL
=====================

# branch_predictor

Dynamic branch predictor and target buffer for the 5-stage MIPS pipeline. It predicts in IF and is trained in ID by the resolved BEQ outcome (`takebranch`). In IF it looks up the fetch PC and supplies a predicted direction and target. In ID it receives the resolved outcome, updates a direct-mapped table of 2-bit saturating counters, and raises a one-cycle flush with the correct redirect PC on a mispredict.

## Interface
Parameters:
- `IDX_BITS`, 6: table index width; `2**IDX_BITS` entries.
- `TAG_BITS`, 8: tag width stored per entry.

Ports (reset is synchronous, active-low):
- `clock`  in  1  sole clock, rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `if_pc`  in  32  fetch PC.
- `pred_taken`  out  1  IF prediction: table hit and counter ≥ WT.
- `pred_target`  out  32  stored target on hit, else `if_pc+4`.
- `id_valid`  in  1  the ID instruction is a real BEQ (opcode equals `BEQ`, not a bubble).
- `id_stall`  in  1  pipeline frozen; suppresses update and flush.
- `id_pc`  in  32  PC of the ID instruction.
- `id_target`  in  32  computed branch target.
- `id_taken`  in  1  resolved outcome (`takebranch`).
- `id_pred_taken`  in  1  prediction carried through IF/ID.
- `id_pred_target`  in  32  predicted target carried through IF/ID.
- `flush`  out  1  mispredict; squash IF/ID.
- `redirect_pc`  out  32  correct next PC when `flush`=1.
- `br_count`  out  32  resolved branches since reset, saturating.
- `mp_count`  out  32  mispredicts since reset, saturating.

## Operation
- Index: `pc[IDX_BITS+1:2]`. Tag: `pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]`.
- Each entry holds `valid`, `tag`, 32-bit `target` and a 2-bit counter.
- Counter states: SNT=00, WNT=01, WT=10, ST=11.
- Lookup is combinational from the registered table.
  - Hit = `valid` and tag match.
  - `pred_taken` = hit and counter[1].
- Update condition: `id_valid & ~id_stall & resetn`.
  - Hit at `id_pc`: taken increments the counter, saturating at ST. Not taken decrements it, saturating at SNT. `target` is rewritten with `id_target` when taken.
  - Miss and taken: allocate the entry (valid=1, new tag, target=`id_target`, counter=WT). This overwrites any previous occupant.
  - Miss and not taken: no table change.
- Mispredict (under the same condition as the update) when either of these holds:
  - `id_taken != id_pred_taken`
  - `id_taken & id_pred_taken & (id_target != id_pred_target)`
- On a mispredict:
  - `flush`=1.
  - `redirect_pc` = `id_target` if taken, else `id_pc+4`.
- `br_count` increments on every update. `mp_count` increments on every mispredict. Both hold at `32'hFFFF_FFFF`.

## Timing
- Reset (`resetn`=0 at a rising edge):
  - All `valid`=0, all counters WNT, `br_count`=`mp_count`=0.
  - `flush`=0 and `redirect_pc`=0 for as long as `resetn`=0.
  - `pred_taken`=0 and `pred_target`=`if_pc+4`, since the table is empty.
  - A reset in mid-operation discards any pending update in that cycle.
- `flush` and `redirect_pc` are combinational from ID inputs, valid in the same cycle as the resolution.
- A table write lands at the rising edge and is visible to lookup in the next cycle.
- Same-cycle read and write to one index: lookup returns the old contents (read-before-write).
- `id_stall`=1: no table, counter or flush activity. The update occurs in the first cycle with `id_stall`=0.
- Counter outputs are registered and reflect the update one cycle later.

## Structure
- The shared package `mips_pkg` holds:
  - the `BEQ` opcode constant;
  - the 2-bit counter enum (SNT/WNT/WT/ST);
  - the reset counter value WNT and the allocation value WT.
- One sub-module, `sat_counter2`: a pure next-state function (state, taken) → state, used once for the update path.
- The table is a register array, not RAM, because reset clears it.

## Test plan
- Reset, then `if_pc`=0x40 → `pred_taken`=0, `pred_target`=0x44, `flush`=0, both counters 0.
- Taken BEQ at `id_pc`=0x40, `id_target`=0x80, `id_pred_taken`=0 → `flush`=1, `redirect_pc`=0x80. On the next cycle, `if_pc`=0x40 gives `pred_taken`=1, `pred_target`=0x80, `mp_count`=1.
- Train 0x40 to ST with 3 taken updates, then 1 not-taken update with `id_pred_taken`=1 → `flush`=1, `redirect_pc`=0x44. The counter is then WT, so `pred_taken` stays 1.
- Aliasing: allocate 0x40, then a taken branch at `0x40 + (1<<(IDX_BITS+2))` → the entry is replaced; lookup at 0x40 misses.
- `id_stall`=1 with a mispredicting ID → `flush`=0, `br_count` unchanged. Deassert the stall → `flush`=1 and one update.
- Same-cycle update and lookup at 0x40 → IF sees the pre-update value. Assert `resetn`=0 mid-sequence → the table and counters clear on the next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcode constants and the branch-predictor
// 2-bit saturating counter encoding.
package mips_pkg;

    localparam logic [5:0] BEQ = 6'b000100;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    localparam ctr_t CTR_RESET = WNT;
    localparam ctr_t CTR_ALLOC = WT;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
module sat_counter2
    import mips_pkg::*;
(
    input  ctr_t i_state,
    input  logic i_taken,
    output ctr_t o_state
);

    always_comb begin
        o_state = i_state;
        if (i_taken) begin
            if (i_state != ST) begin
                o_state = ctr_t'(i_state + 2'd1);
            end
        end else if (i_state != SNT) begin
            o_state = ctr_t'(i_state - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor / target buffer: predicts in IF, trains in ID,
// and raises a same-cycle flush with the correct redirect PC on a mispredict.
module branch_predictor
    import mips_pkg::*;
#(
    parameter int unsigned IDX_BITS = 6,
    parameter int unsigned TAG_BITS = 8
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        id_valid,
    input  logic        id_stall,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_target,
    input  logic        id_taken,
    input  logic        id_pred_taken,
    input  logic [31:0] id_pred_target,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_count,
    output logic [31:0] mp_count
);

    localparam int unsigned ENTRIES = 1 << IDX_BITS;

    // Register array rather than RAM: reset must clear every entry.
    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [31:0]         r_target [ENTRIES];
    ctr_t                r_ctr    [ENTRIES];
    logic [31:0]         r_br_count;
    logic [31:0]         r_mp_count;

    logic [IDX_BITS-1:0] w_if_idx;
    logic [TAG_BITS-1:0] w_if_tag;
    logic                w_if_hit;
    logic [IDX_BITS-1:0] w_id_idx;
    logic [TAG_BITS-1:0] w_id_tag;
    logic                w_id_hit;
    logic                w_upd;
    logic                w_mispredict;
    ctr_t                w_ctr_next;

    assign w_if_idx = if_pc[IDX_BITS+1:2];
    assign w_if_tag = if_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

    assign pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
    assign pred_target = w_if_hit ? r_target[w_if_idx] : if_pc + 32'd4;

    assign w_id_idx = id_pc[IDX_BITS+1:2];
    assign w_id_tag = id_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign w_id_hit = r_valid[w_id_idx] && (r_tag[w_id_idx] == w_id_tag);

    assign w_upd        = id_valid && !id_stall && resetn;
    assign w_mispredict = (id_taken != id_pred_taken) ||
                          (id_taken && id_pred_taken && (id_target != id_pred_target));

    assign flush       = w_upd && w_mispredict;
    assign redirect_pc = !flush   ? '0 :
                         id_taken ? id_target : id_pc + 32'd4;

    sat_counter2 u_sat_counter2 (
        .i_state (r_ctr[w_id_idx]),
        .i_taken (id_taken),
        .o_state (w_ctr_next)
    );

    always_ff @(posedge clock) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= CTR_RESET;
            end
        end else if (w_upd) begin
            if (w_id_hit) begin
                r_ctr[w_id_idx] <= w_ctr_next;
                if (id_taken) begin
                    r_target[w_id_idx] <= id_target;
                end
            end else if (id_taken) begin
                r_valid[w_id_idx]  <= 1'b1;
                r_tag[w_id_idx]    <= w_id_tag;
                r_target[w_id_idx] <= id_target;
                r_ctr[w_id_idx]    <= CTR_ALLOC;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_br_count <= '0;
            r_mp_count <= '0;
        end else begin
            if (w_upd && (r_br_count != '1)) begin
                r_br_count <= r_br_count + 32'd1;
            end
            if (flush && (r_mp_count != '1)) begin
                r_mp_count <= r_mp_count + 32'd1;
            end
        end
    end

    assign br_count = r_br_count;
    assign mp_count = r_mp_count;

endmodule
